// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue.
package fetch_queue_pkg;
   localparam int FQ_W = 16;
   localparam logic [FQ_W-1:0] FQ_NOP = 16'h0800;

   typedef struct packed {
      logic [FQ_W-1:0] instr;
      logic [FQ_W-1:0] pc;
      logic [FQ_W-1:0] pc_inc;
   } fq_entry_t;
endpackage

// File: rtl/fetch_queue_fq_mem.sv
// Entry storage for fetch_queue: one write port, one asynchronous read port, data not reset.
module fq_mem #(
   parameter int DEPTH = 4,
   parameter int DW    = 48
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DW-1:0]            wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DW-1:0]            rdata
);
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode with single-cycle flush.
// Optional same-cycle pass-through when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [W-1:0]           in_instr,
   input  logic [W-1:0]           in_pc,
   input  logic [W-1:0]           in_pc_inc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [W-1:0]           out_instr,
   output logic [W-1:0]           out_pc,
   output logic [W-1:0]           out_pc_inc,
   input  logic                   flush,
   output logic [$clog2(DEPTH):0] count,
   output logic                   err_fq
);
   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0]  head, tail;
   logic [PW:0]    cnt;
   logic           err;
   logic           full, empty;
   logic           push, pop, bypass;
   logic [3*W-1:0] rd_data;

   fq_mem #(
      .DEPTH (DEPTH),
      .DW    (3*W)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (tail),
      .wdata ({in_instr, in_pc, in_pc_inc}),
      .raddr (head),
      .rdata (rd_data)
   );

   assign full  = (cnt == (PW+1)'(DEPTH));
   assign empty = (cnt == '0);

   always_comb begin
`ifdef FETCH_QUEUE_BYPASS_EN
      bypass = empty && in_valid && !flush;
`else
      bypass = 1'b0;
`endif
      // A bypassed entry consumed by decode in the same cycle is never stored.
      push = in_valid && !full && !flush && !(bypass && out_ready);
      pop  = !empty && out_ready && !flush;
   end

   always_comb begin
      in_ready = !full;
      if (bypass) begin
         out_valid  = 1'b1;
         out_instr  = in_instr;
         out_pc     = in_pc;
         out_pc_inc = in_pc_inc;
      end else if (!empty) begin
         out_valid  = 1'b1;
         out_instr  = rd_data[3*W-1:2*W];
         out_pc     = rd_data[2*W-1:W];
         out_pc_inc = rd_data[W-1:0];
      end else begin
         out_valid  = 1'b0;
         out_instr  = W'(FQ_NOP);
         out_pc     = '0;
         out_pc_inc = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else if (flush) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         if (push && !pop)      cnt <= cnt + 1'b1;
         else if (pop && !push) cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          err <= 1'b0;
      else if (in_valid && full && !flush) err <= 1'b1;
   end

   assign count  = cnt;
   assign err_fq = err;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed table, corner sequences, random vs queue model.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int W     = 16;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
   logic [W-1:0]  in_instr = '0, in_pc = '0, in_pc_inc = '0;
   logic          in_ready, out_valid, err_fq;
   logic [W-1:0]  out_instr, out_pc, out_pc_inc;
   logic [2:0]    count;

   int vectors = 0;
   int miscompares = 0;

   fetch_queue #(.DEPTH(DEPTH), .W(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .in_pc_inc(in_pc_inc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .out_pc_inc(out_pc_inc),
      .flush(flush), .count(count), .err_fq(err_fq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [15:0] instr;
      logic [15:0] pc;
      logic        ory;
      logic        fl;
      logic        chk;
      logic [2:0]  cnt;
      logic        rdy;
      logic        err;
      logic        vld;
      logic [15:0] e_instr;
      logic [15:0] e_pc;
   } row_t;

   row_t tbl[$];
   fq_entry_t q[$];
   logic m_err;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic add(input logic iv, input logic [15:0] instr, input logic [15:0] pc,
                      input logic ory, input logic fl, input logic c, input logic [2:0] cnt,
                      input logic rdy, input logic err, input logic vld,
                      input logic [15:0] ei, input logic [15:0] ep);
      row_t r;
      r.iv = iv; r.instr = instr; r.pc = pc; r.ory = ory; r.fl = fl; r.chk = c;
      r.cnt = cnt; r.rdy = rdy; r.err = err; r.vld = vld; r.e_instr = ei; r.e_pc = ep;
      tbl.push_back(r);
   endtask

   function automatic logic [15:0] cpc(input int k);
      return 16'(16'h0100 + 4*k);
   endfunction

   task automatic drive(input logic iv, input logic [15:0] instr, input logic [15:0] pc,
                        input logic ory, input logic fl);
      in_valid  = iv;
      in_instr  = instr;
      in_pc     = pc;
      in_pc_inc = 16'(pc + 16'd2);
      out_ready = ory;
      flush     = fl;
   endtask

   initial begin
      logic [15:0] e_i, e_p, e_pi;
      logic        e_v;
      fq_entry_t   ent;

      // Directed table: each row's checks reflect state before that row's edge.
      add(0, 16'h0, 16'h0, 0, 0, 1, 0, 1, 0, 0, 16'h0800, 16'h0);
      add(1, 16'h1234, 16'h0, 0, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0);
      add(0, 16'h0, 16'h0, 0, 0, 1, 1, 1, 0, 1, 16'h1234, 16'h0);
      add(0, 16'h0, 16'h0, 1, 0, 1, 1, 1, 0, 1, 16'h1234, 16'h0);
      add(0, 16'h0, 16'h0, 0, 0, 1, 0, 1, 0, 0, 16'h0800, 16'h0);
      for (int k = 1; k <= 4; k++)
         add(1, 16'(16'hA000 + k), 16'(16*k), 0, 0, (k != 1), 3'(k-1), 1, 0, (k != 1),
             16'hA001, 16'h0010);
      add(1, 16'hBEEF, 16'hFFF0, 0, 0, 1, 4, 0, 0, 1, 16'hA001, 16'h0010);
      add(0, 16'h0, 16'h0, 1, 0, 1, 4, 0, 1, 1, 16'hA001, 16'h0010);
      for (int k = 2; k <= 4; k++)
         add(0, 16'h0, 16'h0, 1, 0, 1, 3'(5-k), 1, 1, 1, 16'(16'hA000 + k), 16'(16*k));
      add(0, 16'h0, 16'h0, 0, 0, 1, 0, 1, 1, 0, 16'h0800, 16'h0);
      add(1, 16'hC001, cpc(1), 0, 0, 0, 0, 1, 1, 0, 16'h0, 16'h0);
      add(1, 16'hC002, cpc(2), 0, 0, 1, 1, 1, 1, 1, 16'hC001, cpc(1));
      for (int j = 0; j < 10; j++)
         add(1, 16'(16'hC003 + j), cpc(3+j), 1, 0, 1, 2, 1, 1, 1, 16'(16'hC001 + j), cpc(1+j));
      add(1, 16'hC00D, cpc(13), 0, 0, 1, 2, 1, 1, 1, 16'hC00B, cpc(11));
      add(1, 16'hC00E, cpc(14), 1, 1, 1, 3, 1, 1, 1, 16'hC00B, cpc(11));
      add(0, 16'h0, 16'h0, 0, 0, 1, 0, 1, 1, 0, 16'h0800, 16'h0);
      add(0, 16'h0, 16'h0, 1, 0, 1, 0, 1, 1, 0, 16'h0800, 16'h0);

      #12;
      chk("reset_valid", 32'(out_valid), 32'd0);
      chk("reset_instr", 32'(out_instr), 32'h0800);
      chk("reset_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i].iv, tbl[i].instr, tbl[i].pc, tbl[i].ory, tbl[i].fl);
         #1;
         chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
         chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
         chk($sformatf("tbl%0d_err", i), 32'(err_fq), 32'(tbl[i].err));
         if (tbl[i].chk) begin
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].vld));
            chk($sformatf("tbl%0d_instr", i), 32'(out_instr), 32'(tbl[i].e_instr));
            chk($sformatf("tbl%0d_pc", i), 32'(out_pc), 32'(tbl[i].e_pc));
            chk($sformatf("tbl%0d_pcinc", i), 32'(out_pc_inc),
                32'(tbl[i].vld ? 16'(tbl[i].e_pc + 16'd2) : 16'h0));
         end
      end

      // Asynchronous reset between edges with two entries held.
      @(negedge clk); drive(1, 16'h5001, 16'h0200, 0, 0);
      @(negedge clk); drive(1, 16'h5002, 16'h0204, 0, 0);
      @(negedge clk); drive(0, 16'h0, 16'h0, 0, 0);
      #1;
      chk("pre_rst_count", 32'(count), 32'd2);
      #1 rst = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_count", 32'(count), 32'd0);
      chk("async_rst_instr", 32'(out_instr), 32'h0800);
      chk("async_rst_err", 32'(err_fq), 32'd0);
      chk("async_rst_ready", 32'(in_ready), 32'd1);
      @(negedge clk); rst = 1'b1;

      // Empty queue with simultaneous push and pop.
      @(negedge clk); drive(1, 16'hABCD, 16'h0300, 1, 0);
      #1;
      chk("byp_valid", 32'(out_valid), 32'(BYP));
      chk("byp_instr", 32'(out_instr), BYP ? 32'hABCD : 32'h0800);
      @(negedge clk); drive(0, 16'h0, 16'h0, 0, 0);
      #1;
      chk("byp_count", 32'(count), BYP ? 32'd0 : 32'd1);

      @(negedge clk); drive(0, 16'h0, 16'h0, 0, 1);
      q.delete();
      m_err = 1'b0;

      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         drive(($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom),
               ($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0));
         #1;
         if (BYP && q.size() == 0 && in_valid && !flush) begin
            e_v = 1'b1; e_i = in_instr; e_p = in_pc; e_pi = in_pc_inc;
         end else if (q.size() != 0) begin
            e_v = 1'b1; e_i = q[0].instr; e_p = q[0].pc; e_pi = q[0].pc_inc;
         end else begin
            e_v = 1'b0; e_i = FQ_NOP; e_p = '0; e_pi = '0;
         end
         chk("rnd_valid", 32'(out_valid), 32'(e_v));
         chk("rnd_instr", 32'(out_instr), 32'(e_i));
         chk("rnd_pc", 32'(out_pc), 32'(e_p));
         chk("rnd_pcinc", 32'(out_pc_inc), 32'(e_pi));
         chk("rnd_ready", 32'(in_ready), 32'(q.size() < DEPTH));
         chk("rnd_count", 32'(count), 32'(q.size()));
         chk("rnd_err", 32'(err_fq), 32'(m_err));

         if (in_valid && q.size() == DEPTH && !flush) m_err = 1'b1;
         if (flush) q.delete();
         else if (!(BYP && q.size() == 0 && in_valid && out_ready)) begin
            logic was_full;
            was_full = (q.size() == DEPTH);
            if (out_ready && q.size() != 0) void'(q.pop_front());
            if (in_valid && !was_full) begin
               ent.instr = in_instr; ent.pc = in_pc; ent.pc_inc = in_pc_inc;
               q.push_back(ent);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between the fetch stage and decode. It buffers up to DEPTH fetched entries {instr, PC, PC_inc} so fetch can run ahead while decode stalls. Decode consumes entries through a valid/ready handshake. A branch or jump redirect flushes the queue in one cycle, and decode sees a NOP whenever the queue is empty.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- W, 16, width of the instruction and PC fields.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  fetch presents an entry this cycle.
- in_ready  output  1  queue accepts the entry; equals !full.
- in_instr  input  W  fetched instruction.
- in_pc  input  W  PC of that instruction.
- in_pc_inc  input  W  PC+2 of that instruction.
- out_valid  output  1  head entry is valid for decode.
- out_ready  input  1  decode consumes the head this cycle.
- out_instr  output  W  head instruction; FQ_NOP when !out_valid.
- out_pc  output  W  head PC; 0 when !out_valid.
- out_pc_inc  output  W  head PC+2; 0 when !out_valid.
- flush  input  1  redirect: discard all entries.
- count  output  $clog2(DEPTH)+1  number of occupied entries.
- err_fq  output  1  sticky; set when in_valid is high while full and flush is low.

## Operation
- Storage is a circular buffer of DEPTH entries, each 3·W bits, with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
- A push happens when in_valid && in_ready && !flush. The entry is written at tail, then tail++ and count++.
- A pop happens when out_valid && out_ready && !flush. Then head++ and count--.
- Push and pop in the same cycle: both pointers advance and count is unchanged. This is legal at any fill level below full.
- Full (count==DEPTH): in_ready=0. A push is not accepted, even when a pop happens in the same cycle.
- Empty (count==0): out_valid=0, out_instr=FQ_NOP, out_pc and out_pc_inc are 0.
- Flush has highest priority. head, tail and count go to 0 on the next edge, and any same-cycle push or pop is ignored. err_fq is unaffected.
- err_fq clears only on reset.
- Reset: head=tail=count=0, err_fq=0, out_valid=0, in_ready=1, out_instr=FQ_NOP.

## Timing
- Without bypass: an entry pushed at edge N is visible on out_* after edge N, so it can be popped no earlier than the cycle after push.
- in_ready, out_valid and count are decoded from registered state only, with no combinational path from in_valid or out_ready.
- The cycle after a flush edge has out_valid=0 and in_ready=1.
- Reset mid-operation discards all entries asynchronously. out_* go to their empty values immediately, without waiting for a clock edge.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When count==0 and in_valid && !flush, in_* drive out_* combinationally and out_valid=1.
  - If out_ready is also high, the entry is consumed and not written; the pointers do not move.
  - Otherwise the entry is written as a normal push.
  - This creates a combinational path from in_* to out_*.
- FETCH_QUEUE_BYPASS_EN undefined: zero-latency pass-through never occurs, and out_* come from storage only.

## Structure
- The shared package fetch_queue_pkg holds:
  - localparam FQ_NOP = 16'h0800.
  - typedef fq_entry_t = struct {instr, pc, pc_inc}.
- One sub-module, fq_mem: DEPTH×3W register array with one write port and one asynchronous read port, with no reset on the data.
- Pointer, count and flag logic lives in fetch_queue.

## Test plan
- Reset, then push 0x1234/pc 0x0000/pc_inc 0x0002 with out_ready=0 → next cycle out_valid=1, out_instr=0x1234, count=1.
- Push 4 entries with out_ready=0, then drive in_valid=1 → in_ready=0, count=4, err_fq=1 and stays 1; pop 4 times → entries come out in FIFO order, then out_instr=0x0800.
- Hold count=2 with in_valid=out_ready=1 for 10 cycles → count stays 2, order preserved across pointer wrap.
- At count=3, assert flush together with in_valid and out_ready → next cycle count=0, out_valid=0, in_ready=1, and the pushed entry never appears.
- Assert rst low between edges at count=2 → out_valid=0 and count=0 immediately.
- With FETCH_QUEUE_BYPASS_EN, empty queue, in_valid=out_ready=1 and in_instr=0xABCD → out_instr=0xABCD in the same cycle and count stays 0. Without the macro, the same stimulus gives out_valid=0 that cycle.
